// File: rtl/obs_pkg.sv
// Shared definitions for the observer dump scanner: mode encodings, FSM
// states, tag-byte layout and the sweep-index decode.
// The SEND_CSUM state exists only when OBS_DUMP_CSUM_EN is defined.
package obs_pkg;

  localparam int RegBus     = 16;
  localparam int RegAddrBus = 4;
  localparam int ModeBus    = 3;
  localparam int IdxBus     = 5;

  localparam logic [ModeBus-1:0] OBS_MODE_REG   = 3'd0;
  localparam logic [ModeBus-1:0] OBS_MODE_PC    = 3'd1;
  localparam logic [ModeBus-1:0] OBS_MODE_IR    = 3'd2;
  localparam logic [ModeBus-1:0] OBS_MODE_ALU_A = 3'd3;
  localparam logic [ModeBus-1:0] OBS_MODE_ALU_B = 3'd4;
  localparam logic [ModeBus-1:0] OBS_MODE_ALU_O = 3'd5;

  // Bit 7 of a tag byte is always set so the host can resync on tags.
  localparam logic [7:0] TAG_MARK = 8'h80;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SELECT,
    ST_CAPTURE,
    ST_SEND_TAG,
    ST_SEND_HI,
    ST_SEND_LO,
    ST_NEXT,
`ifdef OBS_DUMP_CSUM_EN
    ST_SEND_CSUM,
`endif
    ST_DONE
  } obs_state_e;

  typedef struct packed {
    logic [ModeBus-1:0]    mode;
    logic [RegAddrBus-1:0] sel;
  } obs_item_t;

  // GPRs first (sel = index), then PC, IR, ALU_A, ALU_B, ALU_O with sel = 0.
  function automatic obs_item_t obs_decode(input logic [IdxBus-1:0] idx,
                                           input logic [IdxBus-1:0] num_regs);
    obs_item_t         item;
    logic [IdxBus-1:0] offset;
    item.mode = OBS_MODE_REG;
    item.sel  = '0;
    offset    = idx - num_regs;
    if (idx < num_regs) begin
      item.sel = idx[RegAddrBus-1:0];
    end else begin
      case (offset)
        5'd0:    item.mode = OBS_MODE_PC;
        5'd1:    item.mode = OBS_MODE_IR;
        5'd2:    item.mode = OBS_MODE_ALU_A;
        5'd3:    item.mode = OBS_MODE_ALU_B;
        default: item.mode = OBS_MODE_ALU_O;
      endcase
    end
    return item;
  endfunction

endpackage

// File: rtl/obs_dump_scanner.sv
// Observer dump scanner: walks every visible CPU register through the
// observer port and streams {tag, hi, lo} bytes per item on a valid/ready
// link. Defining OBS_DUMP_CSUM_EN appends an XOR checksum byte per sweep.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start_i, observer selects parked at 0
// SELECT    | mode/sel driven, settle counter running
// CAPTURE   | latch observer data into the word register
// SEND_TAG  | emit {1, mode, sel}
// SEND_HI   | emit word[15:8]
// SEND_LO   | emit word[7:0]
// NEXT      | advance index or finish the sweep
// SEND_CSUM | emit XOR of all bytes of the sweep (optional)
// DONE      | one-cycle done pulse, restart if continuous_i
import obs_pkg::*;

module obs_dump_scanner #(
  parameter int SETTLE_CYCLES = 1,
  parameter int NUM_REGS      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  continuous_i,
  output logic [ModeBus-1:0]    mode_o,
  output logic [RegAddrBus-1:0] reg_sel_o,
  input  logic [RegBus-1:0]     data_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [3:0]        SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [IdxBus-1:0] NREGS       = IdxBus'(NUM_REGS);
  localparam logic [IdxBus-1:0] LAST_IDX    = IdxBus'(NUM_REGS + 4);

  obs_state_e            r_state;
  obs_state_e            w_next_state;
  logic [IdxBus-1:0]     r_idx;
  logic [ModeBus-1:0]    r_mode;
  logic [RegAddrBus-1:0] r_sel;
  logic [3:0]            r_settle;
  logic [RegBus-1:0]     r_word;
`ifdef OBS_DUMP_CSUM_EN
  logic [7:0]            r_csum;
`endif

  logic [7:0]            w_tx_data;
  logic                  w_tx_valid;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_enter_select;
  logic                  w_sweep_start;
  logic [IdxBus-1:0]     w_sel_idx;
  obs_item_t             w_item;

  // Selects are loaded only on SELECT entry so the observer input stays
  // frozen across settle, capture and all send stalls of an item.
  assign w_enter_select = (w_next_state == ST_SELECT) && (r_state != ST_SELECT);
  assign w_sweep_start  = w_enter_select && (r_state != ST_NEXT);
  assign w_sel_idx      = (r_state == ST_NEXT) ? r_idx + 5'd1 : '0;
  assign w_item         = obs_decode(w_sel_idx, NREGS);

  // Next-state and output decode; tx_valid depends on state only.
  always_comb begin
    w_next_state = r_state;
    w_tx_data    = '0;
    w_tx_valid   = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (start_i) w_next_state = ST_SELECT;
      end
      ST_SELECT: begin
        if (r_settle == '0) w_next_state = ST_CAPTURE;
      end
      ST_CAPTURE: w_next_state = ST_SEND_TAG;
      ST_SEND_TAG: begin
        w_tx_valid = 1'b1;
        w_tx_data  = TAG_MARK | {1'b0, r_mode, r_sel};
        if (tx_ready_i) w_next_state = ST_SEND_HI;
      end
      ST_SEND_HI: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_word[15:8];
        if (tx_ready_i) w_next_state = ST_SEND_LO;
      end
      ST_SEND_LO: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_word[7:0];
        if (tx_ready_i) w_next_state = ST_NEXT;
      end
      ST_NEXT: begin
        if (r_idx == LAST_IDX) begin
`ifdef OBS_DUMP_CSUM_EN
          w_next_state = ST_SEND_CSUM;
`else
          w_next_state = ST_DONE;
`endif
        end else begin
          w_next_state = ST_SELECT;
        end
      end
`ifdef OBS_DUMP_CSUM_EN
      ST_SEND_CSUM: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_csum;
        if (tx_ready_i) w_next_state = ST_DONE;
      end
`endif
      ST_DONE: begin
        w_busy       = 1'b0;
        w_done       = 1'b1;
        w_next_state = continuous_i ? ST_SELECT : ST_IDLE;
      end
      default: begin
        w_busy       = 1'b0;
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register plus the index, select, settle and capture datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_mode   <= '0;
      r_sel    <= '0;
      r_settle <= '0;
      r_word   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_enter_select) begin
        r_idx    <= w_sel_idx;
        r_mode   <= w_item.mode;
        r_sel    <= w_item.sel;
        r_settle <= SETTLE_INIT;
      end else if (w_next_state == ST_IDLE) begin
        r_idx  <= '0;
        r_mode <= '0;
        r_sel  <= '0;
      end else if (r_state == ST_SELECT && r_settle != '0) begin
        r_settle <= r_settle - 4'd1;
      end
      if (r_state == ST_CAPTURE) r_word <= data_i;
    end
  end

`ifdef OBS_DUMP_CSUM_EN
  // XOR of every tag/hi/lo byte accepted in the current sweep.
  always_ff @(posedge clk) begin
    if (rst || w_sweep_start) begin
      r_csum <= '0;
    end else if (w_tx_valid && tx_ready_i && r_state != ST_SEND_CSUM) begin
      r_csum <= r_csum ^ w_tx_data;
    end
  end
`endif

  assign mode_o     = r_mode;
  assign reg_sel_o  = r_sel;
  assign tx_data_o  = w_tx_data;
  assign tx_valid_o = w_tx_valid;
  assign busy_o     = w_busy;
  assign done_o     = w_done;

endmodule

// File: tb/tb_obs_dump_scanner.sv
// Self-checking bench for obs_dump_scanner (SETTLE_CYCLES = 3). Expected
// streams come from a list-based model of the sweep; honours OBS_DUMP_CSUM_EN.
module tb_obs_dump_scanner;

  localparam int SETTLE = 3;
  localparam int ITEMS  = 21;
`ifdef OBS_DUMP_CSUM_EN
  localparam int CSUM_BYTES = 1;
`else
  localparam int CSUM_BYTES = 0;
`endif
  localparam int SWEEP_LEN = ITEMS * 3 + CSUM_BYTES;
  localparam int SWEEP_CYC = ITEMS * (1 + SETTLE + 1 + 3) + CSUM_BYTES;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        continuous_i = 1'b0;
  logic [2:0]  mode_o;
  logic [3:0]  reg_sel_o;
  logic [15:0] data_i = '0;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b1;
  logic        busy_o;
  logic        done_o;

  int total = 0;
  int bad   = 0;

  logic [15:0] obs_val [0:20];
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  int          done_cnt = 0;
  int          rdy_mode = 0;
  int          cyc = 0;

  obs_dump_scanner #(.SETTLE_CYCLES(SETTLE), .NUM_REGS(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .continuous_i(continuous_i),
    .mode_o(mode_o), .reg_sel_o(reg_sel_o), .data_i(data_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observer model: register file lookup, X until selects were stable SETTLE cycles.
  function automatic logic [15:0] obs_read(input logic [2:0] m, input logic [3:0] s);
    if (m == 3'd0) return obs_val[s];
    if (m <= 3'd5) return obs_val[15 + int'(m)];
    return 16'hxxxx;
  endfunction

  int         stab = 0;
  logic [6:0] obs_prev = '0;
  always @(negedge clk) begin
    if ({mode_o, reg_sel_o} !== obs_prev) stab = 1;
    else if (stab < 1000) stab++;
    obs_prev = {mode_o, reg_sel_o};
    data_i = (stab > SETTLE) ? obs_read(mode_o, reg_sel_o) : 16'hxxxx;
  end

  // Downstream ready pattern: always, one-in-three, or random.
  always @(posedge clk) begin
    cyc++;
    #1;
    case (rdy_mode)
      1:       tx_ready_i = (cyc % 3 == 0);
      2:       tx_ready_i = 1'($urandom_range(0, 1));
      default: tx_ready_i = 1'b1;
    endcase
  end

  // Stream monitor: collects accepted bytes and checks holds during stalls.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic [6:0] prev_ms = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", tx_valid_o, 1);
        chk("stall_data_hold", tx_data_o, prev_data);
        chk("stall_sel_hold", {mode_o, reg_sel_o}, prev_ms);
      end
      if (tx_valid_o && tx_ready_i) got_q.push_back(tx_data_o);
      if (done_o) done_cnt++;
      prev_stall = tx_valid_o && !tx_ready_i;
      prev_data  = tx_data_o;
      prev_ms    = {mode_o, reg_sel_o};
    end
  end

  function automatic void set_fixed_vals();
    for (int n = 0; n < 16; n++) obs_val[n] = 16'h2000 + 16'(n);
    obs_val[16] = 16'h2333;
    obs_val[17] = 16'h3222;
    obs_val[18] = 16'h1000;
    obs_val[19] = 16'h0100;
    obs_val[20] = 16'h1100;
  endfunction

  function automatic void set_rand_vals();
    for (int n = 0; n < ITEMS; n++) obs_val[n] = 16'($urandom);
  endfunction

  // Expected sweep: per item a tag {1,mode,sel} then value hi, lo.
  function automatic void build_exp();
    int         mode, sel;
    logic [7:0] x;
    logic [7:0] b;
    exp_q.delete();
    x = '0;
    for (int i = 0; i < ITEMS; i++) begin
      if (i < 16) begin mode = 0; sel = i; end
      else begin mode = i - 15; sel = 0; end
      b = 8'(128 + mode * 16 + sel);       exp_q.push_back(b); x ^= b;
      b = obs_val[i][15:8];                 exp_q.push_back(b); x ^= b;
      b = obs_val[i][7:0];                  exp_q.push_back(b); x ^= b;
    end
    if (CSUM_BYTES != 0) exp_q.push_back(x);
  endfunction

  task automatic start_pulse();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int k);
    k = 0;
    while (k < 5000) begin
      @(negedge clk);
      if (k == 0) chk({tag, "_busy_running"}, busy_o, 1);
      if (done_o) break;
      @(posedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, done_o, 1);
    chk({tag, "_busy_at_done"}, busy_o, 0);
    chk({tag, "_valid_at_done"}, tx_valid_o, 0);
  endtask

  task automatic compare_stream(input string tag, input int nsweeps);
    chk({tag, "_byte_count"}, got_q.size(), nsweeps * SWEEP_LEN);
    for (int i = 0; i < got_q.size() && i < nsweeps * SWEEP_LEN; i++)
      chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i % SWEEP_LEN]);
  endtask

  initial begin
    int k;
    int dc;
    set_fixed_vals();

    // reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mode", mode_o, 0);
    chk("rst_sel", reg_sel_o, 0);
    chk("rst_txdata", tx_data_o, 0);
    chk("rst_valid", tx_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("idle_valid", tx_valid_o, 0);
      chk("idle_mode", mode_o, 0);
    end

    // single sweep, ready high, fixed observer contents
    rdy_mode = 0;
    build_exp();
    got_q.delete();
    dc = done_cnt;
    start_pulse();
    wait_done("sweep1", k);
    chk("sweep1_latency", k, SWEEP_CYC);
    @(negedge clk);
    chk("sweep1_done_pulse", done_cnt, dc + 1);
    chk("sweep1_done_low", done_o, 0);
    chk("sweep1_idle_mode", mode_o, 0);
    compare_stream("sweep1", 1);
    chk("sweep1_first0", got_q[0], 8'h80);
    chk("sweep1_first1", got_q[1], 8'h20);
    chk("sweep1_first2", got_q[2], 8'h00);
    chk("sweep1_first3", got_q[3], 8'h81);
    chk("sweep1_first5", got_q[5], 8'h01);
    chk("sweep1_last0", got_q[60], 8'hD0);
    chk("sweep1_last1", got_q[61], 8'h11);
    chk("sweep1_last2", got_q[62], 8'h00);

    // one-in-three backpressure, same contents
    rdy_mode = 1;
    got_q.delete();
    start_pulse();
    wait_done("bp", k);
    @(negedge clk);
    compare_stream("bp", 1);

    // random contents, random backpressure
    set_rand_vals();
    build_exp();
    rdy_mode = 2;
    got_q.delete();
    start_pulse();
    wait_done("rnd", k);
    @(negedge clk);
    compare_stream("rnd", 1);

    // reset after the tenth byte aborts the sweep
    rdy_mode = 0;
    got_q.delete();
    start_pulse();
    k = 0;
    while (k < 500) begin
      @(negedge clk); #1;
      if (got_q.size() >= 10) break;
      k++;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_bytes", got_q.size(), 10);
    chk("abort_mode", mode_o, 0);
    chk("abort_sel", reg_sel_o, 0);
    chk("abort_txdata", tx_data_o, 0);
    chk("abort_valid", tx_valid_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    @(posedge clk); #1 rst = 1'b0;
    got_q.delete();
    start_pulse();
    wait_done("post_abort", k);
    chk("post_abort_latency", k, SWEEP_CYC);
    @(negedge clk);
    compare_stream("post_abort", 1);
    chk("post_abort_first", got_q[0], 8'h80);

    // continuous mode, two back-to-back sweeps, starts while busy ignored
    set_rand_vals();
    build_exp();
    rdy_mode = 2;
    got_q.delete();
    dc = done_cnt;
    continuous_i = 1'b1;
    start_pulse();
    repeat (30) @(posedge clk);
    #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    wait_done("cont1", k);
    @(negedge clk);
    chk("cont_busy_again", busy_o, 1);
    chk("cont_done_low", done_o, 0);
    #1 continuous_i = 1'b0;
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    wait_done("cont2", k);
    @(negedge clk);
    chk("cont_done_pulses", done_cnt, dc + 2);
    compare_stream("cont", 2);
    repeat (20) begin
      @(negedge clk);
      chk("cont_no_requeue_valid", tx_valid_o, 0);
      chk("cont_no_requeue_busy", busy_o, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/obs_dump_scanner.md
Name: obs_dump_scanner

Overview:
- Initiator side of the observer interface: drives the observer's mode/register-select inputs and captures its combinational data output.
- Sweeps the whole visible CPU state (16 GPRs, PC, IR, ALU A/B/O) into a tagged byte stream on a valid/ready port.
- The byte stream feeds the debug UART/host link.

Parameters:
- SETTLE_CYCLES, 1, cycles mode_o/reg_sel_o are held stable before data_i is sampled (legal 1..15).
- NUM_REGS, 16, GPRs swept in mode 0 (legal 1..16).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start_i  in  1  begin one sweep; sampled only in IDLE
- continuous_i  in  1  when high, a new sweep starts automatically after DONE
- mode_o  out  3  to observer mode_i
- reg_sel_o  out  4  to observer reg_sel_i
- data_i  in  16  from observer data_o
- tx_data_o  out  8  stream byte
- tx_valid_o  out  1  stream byte valid
- tx_ready_i  in  1  downstream accepts byte when valid&ready
- busy_o  out  1  high from the cycle after start is accepted until DONE
- done_o  out  1  one-cycle pulse at end of sweep

Behaviour:
- Reset: all outputs 0, FSM to IDLE, item index 0, latched word 0.
- Reset mid-sweep aborts the sweep immediately. The stream is truncated, with no flush.
- Item order (index 0..NUM_REGS+4):
  - index < NUM_REGS: mode 0 (REG), reg_sel = index.
  - Then PC (mode 1), IR (mode 2), ALU_A (mode 3), ALU_B (mode 4), ALU_O (mode 5).
  - reg_sel_o = 0 for all non-register items.
- FSM states: IDLE, SELECT, CAPTURE, SEND_TAG, SEND_HI, SEND_LO, NEXT, [SEND_CSUM], DONE.
  - IDLE: mode_o = 0, reg_sel_o = 0. start_i=1 → SELECT with index 0.
  - SELECT: mode_o/reg_sel_o are registered from the index. Stay SETTLE_CYCLES cycles (settle counter), then → CAPTURE.
  - CAPTURE: latch data_i into a 16-bit word register, → SEND_TAG.
  - SEND_TAG: tx_data_o = {1'b1, mode[2:0], sel[3:0]}.
  - SEND_HI: tx_data_o = word[15:8].
  - SEND_LO: tx_data_o = word[7:0].
  - SEND_* rules:
    - tx_valid_o=1 with tx_data_o held stable until the handshake cycle.
    - Advance on valid&ready. Zero bubble between bytes only across state edges, i.e. one byte max per cycle.
  - NEXT: if index == last → DONE (or SEND_CSUM when enabled). Else index+1 → SELECT.
  - DONE: done_o=1 for one cycle, busy_o drops in the same cycle. Then:
    - continuous_i=1 → SELECT with index 0, busy_o reasserted the next cycle.
    - else → IDLE.
- start_i while busy is ignored, with no queuing.
- tx_valid_o never depends combinationally on tx_ready_i.
- mode_o/reg_sel_o are stable from SELECT entry until the next NEXT; the observer input never changes while data_i is being sampled.
- Default sweep: 21 items, 63 bytes. Minimum latency per item = 1+SETTLE_CYCLES+1+3 cycles with ready held high.

Optional Feature:
- Macro OBS_DUMP_CSUM_EN.
- Defined:
  - An 8-bit XOR accumulator clears at sweep start and XORs every transmitted byte (tag, hi, lo).
  - After the last item, SEND_CSUM emits the accumulator value with the same handshake, then DONE (64 bytes per sweep).
- Undefined: no accumulator and no SEND_CSUM state; NEXT goes directly to DONE.

Decomposition:
- Shared package obs_pkg holds:
  - the mode encoding constants (OBS_MODE_REG=0, PC=1, IR=2, ALU_A=3, ALU_B=4, ALU_O=5);
  - the FSM state enum;
  - the tag-byte layout constant (TAG_MARK bit 7).
- Bus widths come from the existing defines (RegBus, RegAddrBus).
- No sub-module; the index-to-{mode, sel} decode is a function in obs_pkg.

Test Plan:
- Reset then idle: rst=1 for 3 cycles → all outputs 0. start_i=0 for 20 cycles → tx_valid_o stays 0, mode_o=0.
- Single sweep, ready tied high, model observer (GPR n = 16'h2000+n, PC=16'h2333, IR=16'h3222, A=16'h1000, B=16'h0100, O=16'h1100):
  - stream starts 0x80,0x20,0x00, 0x81,0x20,0x01 …
  - ends 0xD0,0x11,0x00;
  - 63 bytes, then one done_o pulse.
- Backpressure: tx_ready_i toggles 1-of-3 cycles → identical 63-byte sequence; tx_data_o stable while valid&!ready; mode_o/reg_sel_o unchanged during stalls.
- Settle check: SETTLE_CYCLES=3, observer model returns X unless its inputs have been stable ≥3 cycles → no X captured.
- Mid-sweep reset after byte 10: outputs 0 next cycle. A fresh start_i yields a full sweep beginning with 0x80.
- Continuous plus checksum: continuous_i=1 with OBS_DUMP_CSUM_EN → back-to-back sweeps of 64 bytes; byte 64 equals the XOR of bytes 1-63. start_i pulses while busy are ignored.
